// File: rtl/midi_tx_arbiter.sv
// Round-robin arbiter sharing midi_out between two message sources.
// Accepts one whole message, pulses tx_start, then self-times the line until it is free again.
module midi_tx_arbiter #(
    parameter int BAUD_CNT_HALF = 1600,
    parameter int GAP_BITS      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_status,
    input  logic [7:0] req0_data1,
    input  logic [7:0] req0_data2,
    input  logic [7:0] req0_bits,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_status,
    input  logic [7:0] req1_data1,
    input  logic [7:0] req1_data2,
    input  logic [7:0] req1_bits,
    output logic       req1_ready,
    output logic [7:0] status,
    output logic [7:0] data1,
    output logic [7:0] data2,
    output logic [7:0] cmd_bits_cnt,
    output logic       tx_start,
    output logic       busy,
    output logic       drop
);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    localparam logic [23:0] BIT_CYC = 24'(2 * BAUD_CNT_HALF);
    localparam logic [23:0] EXTRA   = 24'(GAP_BITS + 1);

    state_t      state, state_nxt;
    logic        last_grant;
    logic        grant;
    logic        accept;
    logic        legal;
    logic [23:0] cnt;

    // A tie goes to whoever was not served last.
    always_comb begin
        if (req0_valid && req1_valid) grant = ~last_grant;
        else                          grant = req1_valid;
    end

    // Ready is also held low while reset is asserted.
    assign req0_ready = rst && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = rst && (state == IDLE) && req1_valid &&  grant;
    assign accept     = req0_ready || req1_ready;
    assign legal      = (cmd_bits_cnt == 8'd10) || (cmd_bits_cnt == 8'd20) ||
                        (cmd_bits_cnt == 8'd30);
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE:  if (accept) state_nxt = START;
            START: begin
                if (legal) begin
                    tx_start  = 1'b1;
                    state_nxt = WAIT;
                end else begin
                    drop      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT:    if (cnt == 24'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status       <= 8'd0;
            data1        <= 8'd0;
            data2        <= 8'd0;
            cmd_bits_cnt <= 8'd0;
            last_grant   <= 1'b1;
            cnt          <= 24'd0;
        end else begin
            if (accept) begin
                status       <= grant ? req1_status : req0_status;
                data1        <= grant ? req1_data1  : req0_data1;
                data2        <= grant ? req1_data2  : req0_data2;
                cmd_bits_cnt <= grant ? req1_bits   : req0_bits;
                last_grant   <= grant;
            end
            // One extra bit period absorbs the baud_clk phase relative to tx_start.
            if (state == START && legal)
                cnt <= ({16'd0, cmd_bits_cnt} + EXTRA) * BIT_CYC - 24'd1;
            else if (state == WAIT && cnt != 24'd0)
                cnt <= cnt - 24'd1;
        end
    end

endmodule

// File: tb/tb_midi_tx_arbiter.sv
// Directed bench for midi_tx_arbiter with BAUD_CNT_HALF=4 (8 clk per bit), GAP_BITS=1.
module tb_midi_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_status, req0_data1, req0_data2, req0_bits;
    logic [7:0] req1_status, req1_data1, req1_data2, req1_bits;
    logic       req0_ready, req1_ready;
    logic [7:0] status, data1, data2, cmd_bits_cnt;
    logic       tx_start, busy, drop;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    midi_tx_arbiter #(.BAUD_CNT_HALF(4), .GAP_BITS(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_status(req0_status), .req0_data1(req0_data1),
        .req0_data2(req0_data2), .req0_bits(req0_bits), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_status(req1_status), .req1_data1(req1_data1),
        .req1_data2(req1_data2), .req1_bits(req1_bits), .req1_ready(req1_ready),
        .status(status), .data1(data1), .data2(data2), .cmd_bits_cnt(cmd_bits_cnt),
        .tx_start(tx_start), .busy(busy), .drop(drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  c0, c1, prev, n, busy_n;
        bit  found;

        rst = 1'b0;
        req0_valid = 0; req0_status = 0; req0_data1 = 0; req0_data2 = 0; req0_bits = 0;
        req1_valid = 0; req1_status = 0; req1_data1 = 0; req1_data2 = 0; req1_bits = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_status", status, 0);
        chk("rst_bits", cmd_bits_cnt, 0);
        @(posedge clk); #1 rst = 1'b1;

        // First message after reset
        req0_status = 8'hB0; req0_data1 = 8'h2E; req0_data2 = 8'h7F; req0_bits = 8'd30;
        req0_valid  = 1'b1;
        @(negedge clk);
        chk("a_ready0", req0_ready, 1);
        chk("a_ready1", req1_ready, 0);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        chk("a_tx_start", tx_start, 1);
        chk("a_busy", busy, 1);
        chk("a_status", status, 8'hB0);
        chk("a_data1", data1, 8'h2E);
        chk("a_data2", data2, 8'h7F);
        chk("a_bits", cmd_bits_cnt, 8'd30);
        chk("a_drop", drop, 0);

        // Reset mid-WAIT with a requester waiting
        repeat (5) @(posedge clk);
        #1 rst = 1'b0; req1_valid = 1'b1;
        @(negedge clk);
        chk("mrst_busy", busy, 0);
        chk("mrst_tx", tx_start, 0);
        chk("mrst_ready1", req1_ready, 0);
        chk("mrst_fields", {status, data1, data2, cmd_bits_cnt}, 32'h0);
        @(posedge clk); #1 rst = 1'b1;

        // Single 30-bit message, req1 queued behind it
        req1_status = 8'h90; req1_data1 = 8'h3C; req1_data2 = 8'h64; req1_bits = 8'd20;
        req0_valid  = 1'b1;
        @(negedge clk);
        chk("b_tie_ready0", req0_ready, 1);
        chk("b_tie_ready1", req1_ready, 0);
        c0 = cyc;
        @(posedge clk); #1 req0_valid = 1'b0;
        found = 0; n = 0; busy_n = 0;
        while (!found && n < 400) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            if (req1_ready) found = 1;
        end
        c1 = cyc;
        chk("b_ready1_gap", c1 - c0, 258);
        chk("b_busy_cycles", busy_n, 257);
        @(posedge clk); #1 req1_valid = 1'b0;
        @(negedge clk);
        chk("b_tx_start", tx_start, 1);
        chk("b_fields", {status, data1, data2, cmd_bits_cnt}, {8'h90, 8'h3C, 8'h64, 8'd20});
        wait_idle("b_idle");

        // Continuous contention, 20-bit messages
        @(posedge clk); #1;
        req0_status = 8'hC1; req0_data1 = 8'h05; req0_data2 = 8'h00; req0_bits = 8'd20;
        req0_valid = 1'b1; req1_valid = 1'b1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clk);
            while (!(req0_ready || req1_ready) && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("c_onehot", {req0_ready, req1_ready} == 2'b01 || {req0_ready, req1_ready} == 2'b10, 1);
            chk("c_grant", req1_ready, k % 2);
            if (k > 0) chk("c_gap", cyc - prev, 178);
            prev = cyc;
        end
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle("c_idle");

        // Illegal length from req1, req0 queued right behind
        @(posedge clk); #1;
        req1_bits = 8'd25; req1_valid = 1'b1;
        @(negedge clk);
        chk("d_ready1", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        req0_status = 8'hB0; req0_data1 = 8'h2E; req0_data2 = 8'h7F; req0_bits = 8'd20;
        req0_valid = 1'b1;
        @(negedge clk);
        chk("d_drop", drop, 1);
        chk("d_no_tx", tx_start, 0);
        chk("d_bits", cmd_bits_cnt, 8'd25);
        chk("d_busy", busy, 1);
        @(negedge clk);
        chk("d_ready0", req0_ready, 1);
        chk("d_drop_gone", drop, 0);
        c0 = cyc;

        // Field stability while the requester changes its data during WAIT
        @(posedge clk); #1 req0_data1 = 8'h11;
        @(negedge clk);
        chk("e_tx_start", tx_start, 1);
        chk("e_data1_latched", data1, 8'h2E);
        repeat (50) @(negedge clk);
        chk("e_data1_hold", data1, 8'h2E);
        chk("e_ready0_wait", req0_ready, 0);
        n = 0;
        while (!req0_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("e_gap", cyc - c0, 178);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        chk("e_data1_new", data1, 8'h11);

        // Withdrawn request during WAIT leaves priority alone
        repeat (10) @(posedge clk);
        #1 req1_status = 8'hE3; req1_bits = 8'd10; req1_valid = 1'b1;
        @(negedge clk);
        chk("f_ready1_wait", req1_ready, 0);
        repeat (3) @(posedge clk);
        #1 req1_valid = 1'b0;
        wait_idle("f_idle");
        @(posedge clk); #1 req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("f_tie_ready1", req1_ready, 1);
        chk("f_tie_ready0", req0_ready, 0);
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("f_status", status, 8'hE3);
        chk("f_tx_start", tx_start, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/midi_tx_arbiter.md
# midi_tx_arbiter

Shares the single MIDI output transmitter (`midi_out`) between two message sources: requester 0 (button/preset commands) and requester 1 (MIDI-thru forwarding from `midi_in`). It accepts one complete message at a time over a valid/ready handshake, arbitrates round-robin, and presents the message fields with a one-cycle start pulse. It then self-times the transmission so a new message is never issued while the transmitter is still shifting bits. It sits in `midi_ctrl` between the request logic and `midi_out`, replacing the direct `btn_pressed` drive.

## Interface
- `BAUD_CNT_HALF`, 1600, clk cycles per half bit period; one bit = 2*BAUD_CNT_HALF cycles.
- `GAP_BITS`, 1, idle bit periods enforced after each message.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low. One clock; the reset is asynchronous and active-low.
- `req0_valid` in 1: requester 0 has a message.
- `req0_status`, `req0_data1`, `req0_data2` in 8 each: requester 0 message bytes.
- `req0_bits` in 8: requester 0 message length in line bits; legal values are 10, 20 or 30.
- `req0_ready` out 1: requester 0 message accepted this cycle.
- `req1_valid`, `req1_status`, `req1_data1`, `req1_data2`, `req1_bits`, `req1_ready`: same set for requester 1.
- `status`, `data1`, `data2` out 8 each: fields to `midi_out`.
- `cmd_bits_cnt` out 8: length to `midi_out`.
- `tx_start` out 1: one-cycle start pulse to `midi_out`.
- `busy` out 1: high when not in IDLE.
- `drop` out 1: one-cycle pulse when an illegal-length message is accepted and discarded.

## Operation
- States: IDLE, START, WAIT, with encoded reset state IDLE.
- **IDLE, grant:**
  - `grant` is combinational from the valids and `last_grant`.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not equal to `last_grant` is granted.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
- **IDLE, handshake:**
  - `reqN_ready = (state==IDLE) && reqN_valid && grant==N`. At most one ready is high per cycle.
  - On a clock edge with `reqN_valid && reqN_ready`: the fields are latched into `status`/`data1`/`data2`/`cmd_bits_cnt`, `last_grant <= N`, and the state goes to START.
- **Illegal length:** if the latched bits are not 10, 20 or 30, the message is still accepted and `last_grant` is still updated. The next cycle pulses `drop`, `tx_start` stays 0, and the state goes to IDLE.
- **START:**
  - `tx_start=1` for exactly this cycle.
  - The wait counter loads `(cmd_bits_cnt + GAP_BITS + 1) * 2*BAUD_CNT_HALF - 1`.
  - The extra +1 bit covers the phase uncertainty of `baud_clk` relative to `tx_start`.
  - Next state is WAIT.
- **WAIT:** the counter decrements each cycle. When it reaches 0 the state goes to IDLE, where a new grant is possible that same IDLE cycle.
- **Output stability:** output fields hold their values from acceptance until the next acceptance. They are never changed during START or WAIT.
- **Requester obligations:**
  - Hold fields stable while valid is high and ready is low.
  - Deasserting valid before ready is legal; nothing is latched.
- **Width rules:**
  - The counter is 24 bits, which is sufficient for 32 bits * 3200 cycles = 102400.
  - The multiply uses constant parameters; `cmd_bits_cnt` is zero-extended to 24 bits before the add.
- **Reset mid-operation:** any state goes to IDLE immediately.
  - `busy`, `tx_start`, `drop`, `reqN_ready` and all output fields become 0.
  - The counter becomes 0 and `last_grant` becomes 1.
  - An in-flight message is lost; `midi_out` shares `rst` and aborts too.

## Timing
- All outputs reset to 0.
- **Latency:** acceptance at edge T; `tx_start` high in cycle T+1; `busy` high from T+1.
- **Next acceptance:**
  - Earliest at cycle T+2+(bits+GAP_BITS+1)*2*BAUD_CNT_HALF.
  - For a dropped message, T+2.
- **Back-to-back:** requester throughput is one message per slot, and under continuous contention grants alternate 0,1,0,1.
- **`drop`:** high in cycle T+1 only, and mutually exclusive with `tx_start`.
- **Valid arriving during START/WAIT:** ready stays low, and the arbiter waits without losing priority state.

## Test plan
With `BAUD_CNT_HALF=4` (bit = 8 clk), `GAP_BITS=1`:
- **Reset values:** rst low mid-WAIT -> all outputs 0, state IDLE. After release, `req0_valid` with B0/2E/7F/30 -> ready the same cycle, `tx_start` next cycle, fields B0/2E/7F/30.
- **Single 30-bit message:** accept at T -> `busy` for 1+256 cycles. With `req1` valid throughout, `req1_ready` first high at T+2+256.
- **Contention:** both valid continuously, 20-bit messages -> grant order 0,1,0,1, with acceptances spaced 2+176 cycles.
- **Illegal length:** `req1_bits=25` -> `req1_ready` pulse, `drop` at T+1, no `tx_start`. A queued `req0` is accepted at T+2.
- **Stability:** change `req0_data1` after acceptance during WAIT -> output `data1` unchanged until the next acceptance.
- **Withdrawn request:** raise and drop `req1_valid` while in WAIT -> no acceptance, `last_grant` unchanged, and the next tie is resolved per the previous `last_grant`.
